edge_histogram_line_tracker: RTL and testbench

//  Parametrised line tracker for YUYV camera streams. Per line: detects luma edges as
//  |Y[n]-Y[n-TAP_DIST]| > threshold and counts them into NUM_BINS horizontal bins.
//  At each frame boundary (vsync): arg-max scan, publish line_position/peak_count, clear bins.

---
 rtl/edge_histogram_line_tracker.sv | 269 ++++++++++++++++++++++++++
 tb/tb_edge_histogram_line_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_histogram_line_tracker.sv
// rtl/edge_histogram_line_tracker.sv - YUYV luma edge histogram with per-frame peak bin publish
//
// Purpose:
//   Finds horizontal luma edges in a YUYV camera stream, where an edge is
//   |Y[n] - Y[n-TAP_DIST]| > threshold. Edges are counted into NUM_BINS
//   equal-width horizontal bins over a whole frame. When vsync rises, the bins
//   are scanned one per cycle for the arg-max. The winning bin index and its
//   count are then published and the bins are cleared. The first frame after
//   reset is only used to synchronise to vsync and is never published.
//
// Ports:
//   pixel_clock    in   camera pixel clock, all logic on the rising edge
//   reset_n        in   asynchronous active-low reset
//   camera_data    in   YUYV byte stream (Y, C, Y, C, ... while href is high)
//   href           in   high while a line is active
//   vsync          in   high during frame blanking
//   threshold      in   unsigned edge threshold, sampled every cycle
//   line_position  out  bin index holding the most edges
//   peak_count     out  edge count in that bin
//   position_valid out  one-cycle pulse when line_position/peak_count update
//
// Optional feature, macro EDGE_TRACK_LOST_DETECT_EN:
//   min_peak       in   minimum peak count for a trustworthy position
//   line_lost      out  set when the published peak is below min_peak. In that
//                       case line_position keeps its previous value.

module edge_histogram_line_tracker #(
  parameter int DATA_W      = 8,
  parameter int LINE_PIXELS = 640,
  parameter int NUM_BINS    = 16,
  parameter int BIN_W       = 16,
  parameter int TAP_DIST    = 6,
  localparam int IDX_W      = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] camera_data,
  input  logic              href,
  input  logic              vsync,
  input  logic [DATA_W-1:0] threshold,
`ifdef EDGE_TRACK_LOST_DETECT_EN
  input  logic [BIN_W-1:0]  min_peak,
  output logic              line_lost,
`endif
  output logic [IDX_W-1:0]  line_position,
  output logic [BIN_W-1:0]  peak_count,
  output logic              position_valid
);

  localparam int BIN_PIX = LINE_PIXELS / NUM_BINS;
  localparam int LIDX_W  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int SUB_W   = (BIN_PIX > 1) ? $clog2(BIN_PIX) : 1;

  localparam logic [LIDX_W-1:0] LIDX_LAST = LIDX_W'(LINE_PIXELS - 1);
  localparam logic [LIDX_W-1:0] LIDX_TAP  = LIDX_W'(TAP_DIST);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(BIN_PIX - 1);
  localparam logic [IDX_W-1:0]  BIN_LAST  = IDX_W'(NUM_BINS - 1);
  localparam logic [BIN_W-1:0]  BIN_MAX   = '1;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_WAIT_LOW,
    ST_ACCUM,
    ST_SCAN,
    ST_PUBLISH
  } state_t;

  state_t              state_q, state_d;

  // Byte phase: 0 = next byte is Y, 1 = next byte is chroma.
  logic                phase_q, phase_d;
  // Index of the next Y sample on this line. It saturates at the last pixel.
  logic [LIDX_W-1:0]   luma_idx_q, luma_idx_d;
  // Position within the current bin, and the current bin. This pair replaces
  // a luma_idx / BIN_PIX divider.
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [IDX_W-1:0]    bin_q, bin_d;
  // taps_q[0] is the newest Y. taps_q[TAP_DIST-1] is the sample compared
  // against the incoming Y.
  logic [DATA_W-1:0]   taps_q [TAP_DIST];
  logic [DATA_W-1:0]   taps_d [TAP_DIST];
  logic [BIN_W-1:0]    bins_q [NUM_BINS];
  logic [BIN_W-1:0]    bins_d [NUM_BINS];

  logic [IDX_W-1:0]    k_q, k_d;
  logic [BIN_W-1:0]    max_q, max_d;
  logic [IDX_W-1:0]    arg_q, arg_d;

  logic [IDX_W-1:0]    line_position_q, line_position_d;
  logic [BIN_W-1:0]    peak_count_q, peak_count_d;
  logic                position_valid_q, position_valid_d;
`ifdef EDGE_TRACK_LOST_DETECT_EN
  logic                line_lost_q, line_lost_d;
`endif

  logic                pix_live;
  logic                y_byte;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     mag;
  logic                edge_hit;

  always_comb begin
    state_d          = state_q;
    phase_d          = phase_q;
    luma_idx_d       = luma_idx_q;
    sub_d            = sub_q;
    bin_d            = bin_q;
    taps_d           = taps_q;
    bins_d           = bins_q;
    k_d              = k_q;
    max_d            = max_q;
    arg_d            = arg_q;
    line_position_d  = line_position_q;
    peak_count_d     = peak_count_q;
    position_valid_d = 1'b0;
`ifdef EDGE_TRACK_LOST_DETECT_EN
    line_lost_d      = line_lost_q;
`endif

    // Bytes only count while accumulating with vsync low. The cycle on which
    // vsync is first seen high belongs to the scan, so an edge arriving on
    // that cycle is dropped.
    pix_live = (state_q == ST_ACCUM) && !vsync && href;
    y_byte   = pix_live && !phase_q;

    // diff is the (DATA_W+1)-bit two's complement difference Y_new - Y_old.
    // mag is its absolute value, which always fits in DATA_W+1 unsigned bits.
    diff     = {1'b0, camera_data} - {1'b0, taps_q[TAP_DIST-1]};
    mag      = diff[DATA_W] ? (~diff + (DATA_W+1)'(1)) : diff;
    edge_hit = y_byte && (luma_idx_q >= LIDX_TAP) && (mag > {1'b0, threshold});

    if (pix_live) begin
      phase_d = ~phase_q;
    end else begin
      phase_d    = 1'b0;
      luma_idx_d = '0;
      sub_d      = '0;
      bin_d      = '0;
    end

    if (y_byte) begin
      taps_d[0] = camera_data;
      for (int i = 1; i < TAP_DIST; i++) begin
        taps_d[i] = taps_q[i-1];
      end
      if (luma_idx_q != LIDX_LAST) begin
        luma_idx_d = luma_idx_q + LIDX_W'(1);
      end
      // After luma_idx saturates, the bin is already the last one. The
      // sub-counter may keep wrapping without effect.
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        if (bin_q != BIN_LAST) begin
          bin_d = bin_q + IDX_W'(1);
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end

    if (edge_hit && (bins_q[bin_q] != BIN_MAX)) begin
      bins_d[bin_q] = bins_q[bin_q] + BIN_W'(1);
    end

    case (state_q)
      ST_ARM: begin
        if (vsync) begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!vsync) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (vsync) begin
          state_d = ST_SCAN;
          k_d     = '0;
          max_d   = '0;
          arg_d   = '0;
        end
      end
      ST_SCAN: begin
        // Strictly-greater update, so ties keep the lowest bin index.
        if (bins_q[k_q] > max_q) begin
          max_d = bins_q[k_q];
          arg_d = k_q;
        end
        if (k_q == BIN_LAST) begin
          state_d = ST_PUBLISH;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      ST_PUBLISH: begin
        for (int i = 0; i < NUM_BINS; i++) begin
          bins_d[i] = '0;
        end
        peak_count_d     = max_q;
        position_valid_d = 1'b1;
`ifdef EDGE_TRACK_LOST_DETECT_EN
        if (max_q < min_peak) begin
          line_lost_d = 1'b1;
        end else begin
          line_lost_d     = 1'b0;
          line_position_d = arg_q;
        end
`else
        line_position_d = arg_q;
`endif
        state_d = ST_WAIT_LOW;
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_ARM;
      phase_q          <= 1'b0;
      luma_idx_q       <= '0;
      sub_q            <= '0;
      bin_q            <= '0;
      for (int i = 0; i < TAP_DIST; i++) begin
        taps_q[i] <= '0;
      end
      for (int i = 0; i < NUM_BINS; i++) begin
        bins_q[i] <= '0;
      end
      k_q              <= '0;
      max_q            <= '0;
      arg_q            <= '0;
      line_position_q  <= '0;
      peak_count_q     <= '0;
      position_valid_q <= 1'b0;
`ifdef EDGE_TRACK_LOST_DETECT_EN
      line_lost_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      luma_idx_q       <= luma_idx_d;
      sub_q            <= sub_d;
      bin_q            <= bin_d;
      taps_q           <= taps_d;
      bins_q           <= bins_d;
      k_q              <= k_d;
      max_q            <= max_d;
      arg_q            <= arg_d;
      line_position_q  <= line_position_d;
      peak_count_q     <= peak_count_d;
      position_valid_q <= position_valid_d;
`ifdef EDGE_TRACK_LOST_DETECT_EN
      line_lost_q      <= line_lost_d;
`endif
    end
  end

  assign line_position  = line_position_q;
  assign peak_count     = peak_count_q;
  assign position_valid = position_valid_q;
`ifdef EDGE_TRACK_LOST_DETECT_EN
  assign line_lost      = line_lost_q;
`endif

endmodule

// File: tb/tb_edge_histogram_line_tracker.sv
// tb/tb_edge_histogram_line_tracker.sv - directed bench for edge_histogram_line_tracker
module tb_edge_histogram_line_tracker;

  logic        pixel_clock = 1'b0;
  logic        reset_n;
  logic [7:0]  camera_data;
  logic        href;
  logic        vsync;
  logic [7:0]  threshold;
  logic [3:0]  line_position;
  logic [15:0] peak_count;
  logic        position_valid;
`ifdef EDGE_TRACK_LOST_DETECT_EN
  logic [15:0] min_peak;
  logic        line_lost;
`endif

  always #5 pixel_clock = ~pixel_clock;

  edge_histogram_line_tracker dut (
    .pixel_clock    (pixel_clock),
    .reset_n        (reset_n),
    .camera_data    (camera_data),
    .href           (href),
    .vsync          (vsync),
    .threshold      (threshold),
`ifdef EDGE_TRACK_LOST_DETECT_EN
    .min_peak       (min_peak),
    .line_lost      (line_lost),
`endif
    .line_position  (line_position),
    .peak_count     (peak_count),
    .position_valid (position_valid)
  );

  // One frame: nrep repetitions of line 1, followed by line 2 when len2 > 0.
  // A line is len Y samples: Y = lo for idx < step, hi from step on.
  typedef struct {
    int len1; int step1; int lo1; int hi1;
    int len2; int step2; int lo2; int hi2;
    int nrep; bit tog; int vs_len;
    int exp_pos; int exp_peak;
  } frame_t;

  frame_t tbl [6];

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always @(negedge pixel_clock) begin
    if (position_valid === 1'b1) pulses++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic send_line(input int len, input int stp, input int lo, input int hi, input bit tog);
    for (int i = 0; i < len; i++) begin
      href        = 1'b1;
      camera_data = (i >= stp) ? 8'(hi) : 8'(lo);
      step();
      camera_data = tog ? ((i % 2 == 1) ? 8'hFF : 8'h00) : 8'h80;
      step();
    end
    href        = 1'b0;
    camera_data = 8'h00;
    step();
    step();
  endtask

  // vsync must already be high. The first step is the edge that samples it.
  // lat is the number of further edges until position_valid is seen, or -1.
  task automatic wait_publish(input int vs_len, output int lat);
    step();
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (n == vs_len) vsync = 1'b0;
      if (position_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_frame(input frame_t f, input int id, input int exp_pos, input int exp_peak);
    int lat;
    int p0;
    p0 = pulses;
    for (int r = 0; r < f.nrep; r++) begin
      send_line(f.len1, f.step1, f.lo1, f.hi1, f.tog);
      if (f.len2 > 0) send_line(f.len2, f.step2, f.lo2, f.hi2, f.tog);
    end
    vsync = 1'b1;
    wait_publish(f.vs_len, lat);
    chk($sformatf("frame%0d latency", id), lat, 17);
    chk($sformatf("frame%0d line_position", id), line_position, exp_pos);
    chk($sformatf("frame%0d peak_count", id), peak_count, exp_peak);
    step();
    chk($sformatf("frame%0d valid one cycle", id), position_valid, 0);
    vsync = 1'b0;
    step();
    step();
    chk($sformatf("frame%0d pulse count", id), pulses - p0, 1);
  endtask

  initial begin
    int lat;
    int p0;
    reset_n     = 1'b0;
    camera_data = 8'h00;
    href        = 1'b0;
    vsync       = 1'b0;
    threshold   = 8'd10;
`ifdef EDGE_TRACK_LOST_DETECT_EN
    min_peak    = 16'd0;
`endif

    tbl[0] = '{128, 100, 0, 200,   0,   0, 0,   0, 4, 1'b0, 20,  2, 24};
    tbl[1] = '{130, 125, 0, 200, 370, 365, 0, 200, 1, 1'b0, 20,  3,  5};
    tbl[2] = '{128, 100, 0,  10,   0,   0, 0,   0, 2, 1'b0, 20,  0,  0};
    tbl[3] = '{128, 100, 0,  11,   0,   0, 0,   0, 1, 1'b0,  3,  2,  6};
    tbl[4] = '{ 50,   0, 200, 200, 60,  0, 0,   0, 1, 1'b1, 20,  0,  0};
    tbl[5] = '{700, 650, 0, 200,   0,   0, 0,   0, 1, 1'b0, 20, 15,  6};

    step();
    step();
    chk("reset line_position", line_position, 0);
    chk("reset peak_count", peak_count, 0);
    chk("reset position_valid", position_valid, 0);
    reset_n = 1'b1;
    step();

    // Lines before the first vsync are discarded, and the vsync pulse only arms.
    for (int r = 0; r < 4; r++) send_line(128, 100, 0, 200, 1'b0);
    chk("discard no pulse before vsync", pulses, 0);
    vsync = 1'b1;
    repeat (20) step();
    vsync = 1'b0;
    step();
    step();
    chk("discard no pulse after vsync", pulses, 0);
    chk("discard line_position", line_position, 0);
    chk("discard peak_count", peak_count, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i], i, tbl[i].exp_pos, tbl[i].exp_peak);
    end

    // Reset in the middle of a scan clears outputs at once and nothing is published.
    for (int r = 0; r < 4; r++) send_line(128, 100, 0, 200, 1'b0);
    vsync = 1'b1;
    repeat (6) step();
    reset_n = 1'b0;
    #1;
    chk("midscan reset line_position", line_position, 0);
    chk("midscan reset peak_count", peak_count, 0);
    chk("midscan reset position_valid", position_valid, 0);
    p0 = pulses;
    step();
    reset_n = 1'b1;
    repeat (30) step();
    chk("midscan reset no publish", pulses - p0, 0);
    vsync = 1'b0;
    step();
    step();

    // The only edge sample arrives on the cycle vsync is first seen high, so it is dropped.
    for (int i = 0; i < 100; i++) begin
      href        = 1'b1;
      camera_data = 8'h00;
      step();
      camera_data = 8'h80;
      step();
    end
    camera_data = 8'd200;
    vsync       = 1'b1;
    wait_publish(20, lat);
    href        = 1'b0;
    camera_data = 8'h00;
    chk("vsync-cycle edge latency", lat, 17);
    chk("vsync-cycle edge line_position", line_position, 0);
    chk("vsync-cycle edge peak_count", peak_count, 0);
    vsync = 1'b0;
    step();
    step();

    run_frame(tbl[0], 10, 2, 24);

`ifdef EDGE_TRACK_LOST_DETECT_EN
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    step();
    step();
    min_peak = 16'd30;
    run_frame(tbl[0], 20, 0, 24);
    chk("lost min30 frame2 line_lost", line_lost, 1);
    min_peak = 16'd20;
    run_frame(tbl[0], 21, 2, 24);
    chk("lost min20 frame2 line_lost", line_lost, 0);
    min_peak = 16'd30;
    run_frame(tbl[1], 22, 2, 5);
    chk("lost min30 frame3 line_lost", line_lost, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
